// File: rtl/rv_pkg.sv
// Shared definitions for the RV32I multi-cycle control path.
// Covers opcodes, FSM state encodings, opcode classes and datapath select/trap codes.
package rv_pkg;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    CLS_NONE   = 4'd0,
    CLS_OP_IMM = 4'd1,
    CLS_OP     = 4'd2,
    CLS_LUI    = 4'd3,
    CLS_AUIPC  = 4'd4,
    CLS_JAL    = 4'd5,
    CLS_JALR   = 4'd6,
    CLS_BRANCH = 4'd7,
    CLS_LOAD   = 4'd8,
    CLS_STORE  = 4'd9
  } opclass_e;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MDR = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_ADDER = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;

  localparam logic [1:0] TC_NONE     = 2'd0;
  localparam logic [1:0] TC_ILLEGAL  = 2'd1;
  localparam logic [1:0] TC_FETCH_TO = 2'd2;
  localparam logic [1:0] TC_DATA_TO  = 2'd3;

endpackage

// File: rtl/rv_mc_ctrl_if.sv
// Memory request handshake between the control FSM (master) and memory (slave).
interface rv_mc_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic addr_sel;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output addr_sel, input mem_ready);
  modport slave  (input mem_req, input mem_we, input addr_sel, output mem_ready);
endinterface

// File: rtl/rv_opclass_dec.sv
// Combinational opcode classifier.
// Also used by the datapath mux logic.
module rv_opclass_dec
  import rv_pkg::*;
(
  input  logic [6:0] opcode,
  output opclass_e   op_class,
  output logic       legal
);

  always_comb begin
    op_class = CLS_NONE;
    legal    = 1'b1;
    case (opcode)
      OP_IMM:  op_class = CLS_OP_IMM;
      OP:      op_class = CLS_OP;
      LUI:     op_class = CLS_LUI;
      AUIPC:   op_class = CLS_AUIPC;
      JAL:     op_class = CLS_JAL;
      JALR:    op_class = CLS_JALR;
      BRANCH:  op_class = CLS_BRANCH;
      LOAD:    op_class = CLS_LOAD;
      STORE:   op_class = CLS_STORE;
      default: begin
        op_class = CLS_NONE;
        legal    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rv_mc_ctrl.sv
// Multi-cycle RV32I control FSM: fetch/decode/exec/mem/wb sequencing, memory
// handshake with timeout trap, and a retired-instruction counter.
module rv_mc_ctrl
  import rv_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  rv_mc_ctrl_if.master     mem,
  input  logic [6:0]       opcode,
  input  logic             br_taken,
  output logic             ir_we,
  output logic             alu_we,
  output logic             mdr_we,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             halted,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret,
  output logic [2:0]       state_o
);

  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  opclass_e         cls_q, cls_d, dec_class_s;
  logic             dec_legal_s;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             mem_req_q, mem_req_d, mem_we_q, mem_we_d, addr_sel_q, addr_sel_d;
  logic             alu_we_q, alu_we_d, rf_we_q, rf_we_d, halted_q, halted_d;
  logic [1:0]       wb_sel_q, wb_sel_d, wb_pc_sel_q, wb_pc_sel_d;
  logic [1:0]       trap_cause_q, trap_cause_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             xfer_s, stall_s, to_hit_s, br_exec_s;

  rv_opclass_dec u_dec (
    .opcode   (opcode),
    .op_class (dec_class_s),
    .legal    (dec_legal_s)
  );

  // Next state, latched class, trap cause and request timeout counter
  always_comb begin
    xfer_s       = mem_req_q && mem.mem_ready;
    stall_s      = mem_req_q && !mem.mem_ready;
    to_hit_s     = stall_s && (to_cnt_q == TO_LIMIT);
    state_d      = state_q;
    cls_d        = cls_q;
    trap_cause_d = trap_cause_q;
    case (state_q)
      ST_FETCH: begin
        if (xfer_s) begin
          state_d = ST_DECODE;
        end else if (to_hit_s) begin
          state_d      = ST_TRAP;
          trap_cause_d = TC_FETCH_TO;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: begin
        cls_d = dec_class_s;
        if (dec_legal_s) begin
          state_d = ST_EXEC;
        end else begin
          state_d      = ST_TRAP;
          trap_cause_d = TC_ILLEGAL;
        end
      end
      ST_EXEC: begin
        if ((cls_q == CLS_LOAD) || (cls_q == CLS_STORE)) begin
          state_d = ST_MEM;
        end else if (cls_q == CLS_BRANCH) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (xfer_s) begin
          state_d = (cls_q == CLS_STORE) ? ST_FETCH : ST_WB;
        end else if (to_hit_s) begin
          state_d      = ST_TRAP;
          trap_cause_d = TC_DATA_TO;
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_WB:   state_d = ST_FETCH;
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_FETCH;
    endcase

    // Any state change also covers entry into FETCH or MEM
    if ((state_d != state_q) || xfer_s) begin
      to_cnt_d = '0;
    end else if (stall_s) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end else begin
      to_cnt_d = to_cnt_q;
    end
  end

  // State-driven outputs, decoded from the next state so they are registered
  always_comb begin
    mem_req_d   = (state_d == ST_FETCH) || (state_d == ST_MEM);
    mem_we_d    = (state_d == ST_MEM) && (cls_d == CLS_STORE);
    addr_sel_d  = (state_d == ST_MEM);
    alu_we_d    = (state_d == ST_EXEC);
    rf_we_d     = (state_d == ST_WB);
    halted_d    = (state_d == ST_TRAP);
    wb_sel_d    = WB_ALU;
    wb_pc_sel_d = PC_PLUS4;
    if (state_d == ST_WB) begin
      case (cls_d)
        CLS_LOAD: begin
          wb_sel_d    = WB_MDR;
          wb_pc_sel_d = PC_PLUS4;
        end
        CLS_JAL: begin
          wb_sel_d    = WB_ALU;
          wb_pc_sel_d = PC_ADDER;
        end
        CLS_JALR: begin
          wb_sel_d    = WB_PC4;
          wb_pc_sel_d = PC_ALU;
        end
        default: begin
          wb_sel_d    = WB_ALU;
          wb_pc_sel_d = PC_PLUS4;
        end
      endcase
    end else begin
      wb_sel_d    = WB_ALU;
      wb_pc_sel_d = PC_PLUS4;
    end
  end

  // Handshake- and branch-qualified strobes plus retirement count
  always_comb begin
    br_exec_s = (state_q == ST_EXEC) && (cls_q == CLS_BRANCH);
    ir_we     = (state_q == ST_FETCH) && xfer_s;
    mdr_we    = (state_q == ST_MEM) && xfer_s && (cls_q == CLS_LOAD);
    pc_we     = br_exec_s
             || ((state_q == ST_MEM) && xfer_s && (cls_q == CLS_STORE))
             || (state_q == ST_WB);
    if (br_exec_s && br_taken) begin
      pc_sel = PC_ADDER;
    end else begin
      pc_sel = wb_pc_sel_q;
    end
    instret_d = instret_q + CNT_W'(pc_we);
  end

  // Control FSM registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_FETCH;
      cls_q        <= CLS_NONE;
      to_cnt_q     <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      addr_sel_q   <= 1'b0;
      alu_we_q     <= 1'b0;
      rf_we_q      <= 1'b0;
      halted_q     <= 1'b0;
      wb_sel_q     <= WB_ALU;
      wb_pc_sel_q  <= PC_PLUS4;
      trap_cause_q <= TC_NONE;
      instret_q    <= '0;
    end else begin
      state_q      <= state_d;
      cls_q        <= cls_d;
      to_cnt_q     <= to_cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      addr_sel_q   <= addr_sel_d;
      alu_we_q     <= alu_we_d;
      rf_we_q      <= rf_we_d;
      halted_q     <= halted_d;
      wb_sel_q     <= wb_sel_d;
      wb_pc_sel_q  <= wb_pc_sel_d;
      trap_cause_q <= trap_cause_d;
      instret_q    <= instret_d;
    end
  end

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_we   = mem_we_q;
  assign mem.addr_sel = addr_sel_q;
  assign alu_we       = alu_we_q;
  assign rf_we        = rf_we_q;
  assign wb_sel       = wb_sel_q;
  assign halted       = halted_q;
  assign trap_cause   = trap_cause_q;
  assign instret      = instret_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_rv_mc_ctrl.sv
// Directed self-checking bench for rv_mc_ctrl (TIMEOUT = 4).
module tb_rv_mc_ctrl;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  opcode;
  logic        br_taken;
  logic        ir_we, alu_we, mdr_we, rf_we, pc_we, halted;
  logic [1:0]  wb_sel, pc_sel, trap_cause;
  logic [31:0] instret;
  logic [2:0]  state_o;

  int          n_checks;
  int          n_fail;
  int unsigned exp_instret;

  rv_mc_ctrl_if mem_if ();

  rv_mc_ctrl #(.TIMEOUT(4), .CNT_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem        (mem_if),
    .opcode     (opcode),
    .br_taken   (br_taken),
    .ir_we      (ir_we),
    .alu_we     (alu_we),
    .mdr_we     (mdr_we),
    .rf_we      (rf_we),
    .wb_sel     (wb_sel),
    .pc_we      (pc_we),
    .pc_sel     (pc_sel),
    .halted     (halted),
    .trap_cause (trap_cause),
    .instret    (instret),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Non-memory instruction: optional fetch wait cycles, then DECODE, EXEC, WB
  task automatic run_alu(input string tag, input logic [6:0] op, input int fwait,
                         input logic [1:0] exp_wb, input logic [1:0] exp_pc);
    opcode = op;
    for (int i = 0; i < fwait; i++) begin
      mem_if.mem_ready = 1'b0;
      #1;
      check_val({tag, "_fw_state"}, 32'(state_o), 32'(ST_FETCH));
      check_val({tag, "_fw_req"}, 32'(mem_if.mem_req), 32'd1);
      check_val({tag, "_fw_ir"}, 32'(ir_we), 32'd0);
      step();
    end
    mem_if.mem_ready = 1'b1;
    #1;
    check_val({tag, "_ir_we"}, 32'(ir_we), 32'd1);
    check_val({tag, "_f_asel"}, 32'(mem_if.addr_sel), 32'd0);
    check_val({tag, "_f_we"}, 32'(mem_if.mem_we), 32'd0);
    step();
    #1;
    check_val({tag, "_dec_state"}, 32'(state_o), 32'(ST_DECODE));
    check_val({tag, "_dec_req"}, 32'(mem_if.mem_req), 32'd0);
    step();
    #1;
    check_val({tag, "_ex_alu"}, 32'(alu_we), 32'd1);
    check_val({tag, "_ex_pcwe"}, 32'(pc_we), 32'd0);
    check_val({tag, "_ex_rfwe"}, 32'(rf_we), 32'd0);
    step();
    #1;
    check_val({tag, "_wb_state"}, 32'(state_o), 32'(ST_WB));
    check_val({tag, "_wb_rfwe"}, 32'(rf_we), 32'd1);
    check_val({tag, "_wb_pcwe"}, 32'(pc_we), 32'd1);
    check_val({tag, "_wb_sel"}, 32'(wb_sel), 32'(exp_wb));
    check_val({tag, "_pc_sel"}, 32'(pc_sel), 32'(exp_pc));
    step();
    exp_instret++;
    #1;
    check_val({tag, "_instret"}, instret, exp_instret);
    check_val({tag, "_req_next"}, 32'(mem_if.mem_req), 32'd1);
  endtask

  // LOAD or STORE with zero-wait fetch and dwait data wait cycles
  task automatic run_mem(input string tag, input logic [6:0] op, input int dwait);
    logic is_st;
    is_st  = (op == STORE);
    opcode = op;
    mem_if.mem_ready = 1'b1;
    #1;
    check_val({tag, "_ir_we"}, 32'(ir_we), 32'd1);
    step();
    #1;
    check_val({tag, "_dec_state"}, 32'(state_o), 32'(ST_DECODE));
    step();
    mem_if.mem_ready = 1'b0;
    #1;
    check_val({tag, "_ex_alu"}, 32'(alu_we), 32'd1);
    check_val({tag, "_ex_req"}, 32'(mem_if.mem_req), 32'd0);
    step();
    for (int i = 0; i < dwait; i++) begin
      #1;
      check_val({tag, "_mw_req"}, 32'(mem_if.mem_req), 32'd1);
      check_val({tag, "_mw_asel"}, 32'(mem_if.addr_sel), 32'd1);
      check_val({tag, "_mw_we"}, 32'(mem_if.mem_we), 32'(is_st));
      check_val({tag, "_mw_mdr"}, 32'(mdr_we), 32'd0);
      check_val({tag, "_mw_pcwe"}, 32'(pc_we), 32'd0);
      step();
    end
    mem_if.mem_ready = 1'b1;
    #1;
    check_val({tag, "_m_req"}, 32'(mem_if.mem_req), 32'd1);
    check_val({tag, "_m_asel"}, 32'(mem_if.addr_sel), 32'd1);
    check_val({tag, "_m_we"}, 32'(mem_if.mem_we), 32'(is_st));
    check_val({tag, "_m_mdr"}, 32'(mdr_we), 32'(!is_st));
    check_val({tag, "_m_pcwe"}, 32'(pc_we), 32'(is_st));
    check_val({tag, "_m_pcsel"}, 32'(pc_sel), 32'(PC_PLUS4));
    step();
    if (!is_st) begin
      #1;
      check_val({tag, "_wb_state"}, 32'(state_o), 32'(ST_WB));
      check_val({tag, "_wb_rfwe"}, 32'(rf_we), 32'd1);
      check_val({tag, "_wb_sel"}, 32'(wb_sel), 32'(WB_MDR));
      check_val({tag, "_wb_pcwe"}, 32'(pc_we), 32'd1);
      check_val({tag, "_wb_pcsel"}, 32'(pc_sel), 32'(PC_PLUS4));
      step();
    end
    exp_instret++;
    #1;
    check_val({tag, "_instret"}, instret, exp_instret);
    check_val({tag, "_end_state"}, 32'(state_o), 32'(ST_FETCH));
  endtask

  task automatic run_branch(input string tag, input logic taken);
    opcode = BRANCH;
    mem_if.mem_ready = 1'b1;
    #1;
    check_val({tag, "_ir_we"}, 32'(ir_we), 32'd1);
    step();
    step();
    br_taken = taken;
    #1;
    check_val({tag, "_ex_state"}, 32'(state_o), 32'(ST_EXEC));
    check_val({tag, "_ex_alu"}, 32'(alu_we), 32'd1);
    check_val({tag, "_ex_pcwe"}, 32'(pc_we), 32'd1);
    check_val({tag, "_ex_pcsel"}, 32'(pc_sel), taken ? 32'(PC_ADDER) : 32'(PC_PLUS4));
    check_val({tag, "_ex_rfwe"}, 32'(rf_we), 32'd0);
    step();
    br_taken = 1'b0;
    exp_instret++;
    #1;
    check_val({tag, "_next_state"}, 32'(state_o), 32'(ST_FETCH));
    check_val({tag, "_rfwe"}, 32'(rf_we), 32'd0);
    check_val({tag, "_instret"}, instret, exp_instret);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) step();
    rst_n = 1'b1;
    exp_instret = 0;
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    exp_instret = 0;
    opcode = 7'd0;
    br_taken = 1'b0;
    mem_if.mem_ready = 1'b0;
    do_reset(2);
    #1;
    check_val("rst_state", 32'(state_o), 32'(ST_FETCH));
    check_val("rst_req", 32'(mem_if.mem_req), 32'd0);
    check_val("rst_halted", 32'(halted), 32'd0);
    check_val("rst_cause", 32'(trap_cause), 32'(TC_NONE));
    check_val("rst_instret", instret, 32'd0);
    check_val("rst_pcwe", 32'(pc_we), 32'd0);
    step();
    #1;
    check_val("rst_req_rise", 32'(mem_if.mem_req), 32'd1);

    run_alu("op", OP, 0, WB_ALU, PC_PLUS4);
    run_mem("load_w3", LOAD, 3);
    run_branch("br_t", 1'b1);
    run_branch("br_nt", 1'b0);
    check_val("br_instret_pair", instret, 32'd4);
    run_mem("store", STORE, 0);
    run_alu("jal", JAL, 0, WB_ALU, PC_ADDER);
    run_alu("jalr", JALR, 0, WB_PC4, PC_ALU);

    // Reset while a data request is outstanding
    opcode = LOAD;
    mem_if.mem_ready = 1'b1;
    step();
    step();
    mem_if.mem_ready = 1'b0;
    step();
    #1;
    check_val("mid_mem_state", 32'(state_o), 32'(ST_MEM));
    check_val("mid_mem_req", 32'(mem_if.mem_req), 32'd1);
    do_reset(2);
    mem_if.mem_ready = 1'b1;
    #1;
    check_val("mrst_state", 32'(state_o), 32'(ST_FETCH));
    check_val("mrst_req", 32'(mem_if.mem_req), 32'd0);
    check_val("mrst_ir_ignored", 32'(ir_we), 32'd0);
    check_val("mrst_instret", instret, 32'd0);
    check_val("mrst_halted", 32'(halted), 32'd0);
    step();
    #1;
    check_val("mrst_req_rise", 32'(mem_if.mem_req), 32'd1);
    run_alu("op2", OP, 0, WB_ALU, PC_PLUS4);

    // Illegal opcode traps after DECODE and stays put
    opcode = 7'b0000000;
    mem_if.mem_ready = 1'b1;
    step();
    #1;
    check_val("ill_dec", 32'(state_o), 32'(ST_DECODE));
    step();
    #1;
    check_val("ill_state", 32'(state_o), 32'(ST_TRAP));
    check_val("ill_cause", 32'(trap_cause), 32'(TC_ILLEGAL));
    check_val("ill_halted", 32'(halted), 32'd1);
    check_val("ill_instret", instret, exp_instret);
    for (int i = 0; i < 20; i++) begin
      #1;
      check_val("trap_req", 32'(mem_if.mem_req), 32'd0);
      check_val("trap_pcwe", 32'(pc_we), 32'd0);
      step();
    end
    check_val("trap_hold_state", 32'(state_o), 32'(ST_TRAP));

    // Fetch timeout: four unanswered request cycles
    do_reset(1);
    mem_if.mem_ready = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      #1;
      check_val("fto_wait_state", 32'(state_o), 32'(ST_FETCH));
      check_val("fto_wait_req", 32'(mem_if.mem_req), 32'd1);
      step();
    end
    #1;
    check_val("fto_state", 32'(state_o), 32'(ST_TRAP));
    check_val("fto_cause", 32'(trap_cause), 32'(TC_FETCH_TO));
    check_val("fto_halted", 32'(halted), 32'd1);
    check_val("fto_req", 32'(mem_if.mem_req), 32'd0);

    // Ready on the limit cycle completes the fetch
    do_reset(1);
    check_val("rst2_halted", 32'(halted), 32'd0);
    step();
    run_alu("lui_fw3", LUI, 3, WB_ALU, PC_PLUS4);

    // Data timeout on a load
    opcode = LOAD;
    mem_if.mem_ready = 1'b1;
    step();
    step();
    mem_if.mem_ready = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      #1;
      check_val("dto_wait_state", 32'(state_o), 32'(ST_MEM));
      step();
    end
    #1;
    check_val("dto_state", 32'(state_o), 32'(ST_TRAP));
    check_val("dto_cause", 32'(trap_cause), 32'(TC_DATA_TO));
    check_val("dto_instret", instret, exp_instret);
    check_val("dto_req", 32'(mem_if.mem_req), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
